// File: rtl/seq_mult16_pkg.sv
// Shared constants and state encoding for the sequential 16x16 shift-and-add multiplier.
package seq_mult16_pkg;

  localparam int MULT_WIDTH = 16;
  localparam int MULT_ITERS = 16;
  localparam int CNT_W      = $clog2(MULT_ITERS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_mult16_if.sv
// Start/busy/done handshake and operand/product bus between control logic and seq_mult16.
interface seq_mult16_if;
  import seq_mult16_pkg::*;

  logic                      start;
  logic [MULT_WIDTH-1:0]     a;
  logic [MULT_WIDTH-1:0]     b;
  logic                      busy;
  logic                      done;
  logic [2*MULT_WIDTH-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult16_fulladder16.sv
// Combinational 16-bit adder with carry-in and carry-out; the multiplier's accumulation datapath.
module fulladder16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_ci,
  output logic [15:0] o_sum,
  output logic        o_co
);

  assign {o_co, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {16'b0, i_ci};

endmodule

// File: rtl/seq_mult16.sv
// Sequential 16x16 unsigned shift-and-add multiplier: one adder pass per cycle, 16 iterations,
// start/busy/done handshake; product holds until the next accepted start.
module seq_mult16
  import seq_mult16_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_mult16_if.slave  bus
);

  // The datapath adder is a fixed 16-bit block, so no other width can be built.
  if (WIDTH != MULT_WIDTH) begin : g_width_check
    $error("seq_mult16: WIDTH must be %0d", MULT_WIDTH);
  end

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULT_ITERS - 1);

  state_t                  r_state;
  logic [MULT_WIDTH-1:0]   r_hi;
  logic [MULT_WIDTH-1:0]   r_lo;
  logic [MULT_WIDTH-1:0]   r_mcand;
  logic [CNT_W-1:0]        r_count;
  logic                    r_busy;
  logic                    r_done;
  logic [2*MULT_WIDTH-1:0] r_product;

  logic [MULT_WIDTH-1:0]   w_addend;
  logic [MULT_WIDTH-1:0]   w_sum;
  logic                    w_co;
  logic [MULT_WIDTH-1:0]   w_hi_next;
  logic [MULT_WIDTH-1:0]   w_lo_next;

  assign w_addend = r_lo[0] ? r_mcand : '0;

  fulladder16 u_adder (
    .i_a   (r_hi),
    .i_b   (w_addend),
    .i_ci  (1'b0),
    .o_sum (w_sum),
    .o_co  (w_co)
  );

  // The carry becomes bit 31 of the shifted partial product; dropping it loses the top bit.
  assign w_hi_next = {w_co, w_sum[MULT_WIDTH-1:1]};
  assign w_lo_next = {w_sum[0], r_lo[MULT_WIDTH-1:1]};

  // NOTE: all state is updated with non-blocking assignments so every register samples
  // pre-edge values; blocking here would let later statements see half-updated state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mcand   <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mcand   <= bus.a;
            r_lo      <= bus.b;
            r_hi      <= '0;
            r_count   <= '0;
            r_product <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_RUN;
          end else begin
            r_state   <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_hi    <= w_hi_next;
          r_lo    <= w_lo_next;
          r_count <= r_count + 1'b1;
          if (r_count == LAST_ITER) begin
            r_product <= {w_hi_next, w_lo_next};
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;

endmodule

// File: tb/tb_seq_mult16.sv
// Self-checking bench for seq_mult16: vector table, hand-written corner sequences, scoreboard queue.
module tb_seq_mult16;
  import seq_mult16_pkg::*;

  logic clk;
  logic rst_n;

  seq_mult16_if m ();

  seq_mult16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected product.
  always @(negedge clk) begin
    if (rst_n && m.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("sb_product", m.product, sb_q.pop_front());
      end
    end
  end

  // Called at a negedge; start is accepted at the next posedge (edge t).
  // glitch_at: busy cycle in which a spurious start with a=b=7 is driven (0 = none).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                       input int glitch_at);
    int n_busy;
    int lat;
    n_busy  = 0;
    m.start = 1'b1;
    m.a     = a;
    m.b     = b;
    sb_q.push_back(exp);
    @(negedge clk);
    lat     = 1;
    m.start = 1'b0;
    m.a     = 16'($urandom);
    m.b     = 16'($urandom);
    check("prod_cleared", m.product, 32'd0);
    while (m.done !== 1'b1 && lat < 40) begin
      if (m.busy === 1'b1) n_busy++;
      @(negedge clk);
      lat++;
      m.start = (lat == glitch_at);
      if (lat == glitch_at) begin
        m.a = 16'd7;
        m.b = 16'd7;
      end else begin
        m.a = 16'($urandom);
        m.b = 16'($urandom);
      end
    end
    m.start = 1'b0;
    check("done_latency", 32'(lat), 32'd17);
    check("busy_cycles", 32'(n_busy), 32'd16);
    check("busy_low_at_done", {31'd0, m.busy}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, m.done}, 32'd0);
    check("product_held", m.product, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   lat;
    int   seen;
    logic [15:0] ra;
    logic [15:0] rb;

    vecs[0] = '{16'd3,    16'd5,    32'h0000_000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{16'h1234, 16'h0000, 32'h0000_0000};
    vecs[3] = '{16'h0000, 16'hBEEF, 32'h0000_0000};
    vecs[4] = '{16'h00FF, 16'h0101, 32'h0000_FFFF};
    vecs[5] = '{16'h8000, 16'h8000, 32'h4000_0000};
    vecs[6] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};

    // Reset, with start asserted during reset: reset must win.
    rst_n   = 1'b0;
    m.start = 1'b1;
    m.a     = 16'd9;
    m.b     = 16'd9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, m.busy}, 32'd0);
    check("rst_done", {31'd0, m.done}, 32'd0);
    check("rst_product", m.product, 32'd0);
    m.start = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, m.busy}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp, 0);
    end

    // Start pulse with new operands while busy must be ignored.
    do_op(16'd3, 16'd5, 32'h0000_000F, 4);

    // Reset mid-operation: partial result discarded, no done pulse.
    m.start = 1'b1;
    m.a     = 16'h00FF;
    m.b     = 16'h0101;
    @(negedge clk);
    m.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", {31'd0, m.busy}, 32'd0);
    check("midrst_done", {31'd0, m.done}, 32'd0);
    check("midrst_product", m.product, 32'd0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (m.done === 1'b1 || m.busy === 1'b1) seen++;
    end
    check("midrst_quiet", 32'(seen), 32'd0);
    do_op(16'h00FF, 16'h0101, 32'h0000_FFFF, 0);

    // Start held high: back-to-back operations every 17 cycles.
    m.start = 1'b1;
    m.a     = 16'd2;
    m.b     = 16'd9;
    sb_q.push_back(32'h12);
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      do begin
        @(negedge clk);
        lat++;
      end while (m.done !== 1'b1 && lat < 40);
      check("b2b_interval", 32'(lat), 32'd17);
      check("b2b_product", m.product, 32'h12);
      if (i < 2) begin
        sb_q.push_back(32'h12);
        @(negedge clk);
        check("b2b_cleared", m.product, 32'd0);
        lat = 1;
      end else begin
        m.start = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_hold", m.product, 32'h12);

    // Random operands checked against a plain multiply.
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_op(ra, rb, 32'(ra) * 32'(rb), 0);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult16.md
Name: seq_mult16

Overview:
- Sequential 16x16 unsigned shift-and-add multiplier that consumes the 16-bit adder's SUM/CO every cycle as its accumulation datapath.
- Sits directly downstream of fulladder16: registers the adder result, shifts it, and feeds the upper partial product back in as the next adder operand.
- Produces a 32-bit product after 16 iterations, with a start/busy/done handshake toward the control logic.

Parameters:
- WIDTH, 16, operand width. Only 16 is supported because the datapath adder is fixed at 16 bits. Instantiation with any other value is a configuration error (elaboration check).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request a multiply; sampled only when not busy
- a  input  16  multiplicand, captured on an accepted start
- b  input  16  multiplier, captured on an accepted start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when product becomes valid
- product  output  32  result; held stable until the next accepted start

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. Reset is sampled only on a clk rising edge.
- Reset values: state=IDLE, busy=0, done=0, product=0, count=0, internal hi/lo/mcand=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --(count==15 at edge)--> DONE.
  - DONE --start--> RUN.
  - DONE --!start--> IDLE.
- Accept: start=1 in IDLE or DONE at edge t. At that edge: mcand<=a, lo<=b, hi<=0, count<=0, product<=0; busy=1 from cycle t+1.
- Iteration (each RUN edge):
  - Adder inputs are A=hi[15:0], B=(lo[0] ? mcand : 0).
  - Update {hi,lo} <= {CO, SUM, lo} >> 1, i.e. hi<={CO,SUM[15:1]}, lo<={SUM[0],lo[15:1]}.
  - count<=count+1.
  - The adder's CO must be kept as the 17th bit of the shifted partial product; dropping it is a bug.
- Completion:
  - On the edge where count==15, the final iteration completes, product<={hi,lo} (post-shift value), and state<=DONE.
  - busy is high exactly 16 cycles.
  - done is high exactly 1 cycle, the cycle after the last busy cycle.
- Latency: accepted start at edge t -> done=1 and product valid during cycle t+17. With start held high, back-to-back operations run every 17 cycles.
- Ordering: product changes only at an accepted start (cleared to 0) and at completion. Between completion and the next start it holds.
- start while busy: ignored. a/b changes while busy have no effect.
- start during the DONE cycle: accepted. done still pulses that cycle, and product is cleared at the edge.
- Reset mid-operation: on the next edge with rst_n=0, return to IDLE and apply all reset values. The partial result is discarded and no done pulse is generated.
- rst_n=0 and start=1 on the same edge: reset wins.
- Overflow is impossible: 16x16 unsigned fits in 32 bits; no saturation or flags.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10 (2'b11 recovers to IDLE);
  - MULT_WIDTH=16;
  - MULT_ITERS=16.
- One sub-module: reuse the existing fulladder16 as the combinational adder with carry-in tied 0.
- Control FSM, counter and shift registers live in seq_mult16 itself.

Test Plan:
- Reset, then a=3, b=5, start pulse -> busy high 16 cycles; done pulse in cycle t+17; product=32'h0000_000F held afterwards.
- a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE_0001; exercises the CO path every iteration.
- a=16'h1234, b=0, then a=0, b=16'hBEEF -> product=0 both times; done timing unchanged.
- Start at t; at t+4 pulse start with a=7, b=7 and change a/b -> ignored. First result 3x5=15 at t+17, unaffected.
- Start 16'h00FF x 16'h0101; drive rst_n=0 at t+8 for one edge -> next cycle busy=0, done=0, product=0; no done pulse later. A new start then completes normally with 32'h0000_FFFF.
- start held high continuously with a=2, b=9 -> done pulses every 17 cycles; product 32'h12 each time, cleared to 0 at each accepted start.
